// File: rtl/mcu_link_pkg.sv
// Shared codes, special-word constants and RX field layout for the MCU<->ROCSTAR link.
package mcu_link_pkg;

  localparam logic [3:0] K_IDLE0 = 4'b0111;
  localparam logic [3:0] K_IDLE1 = 4'b1011;
  localparam logic [3:0] K_IDLE2 = 4'b1101;
  localparam logic [3:0] K_IDLE3 = 4'b1110;
  localparam logic [3:0] K_NCOIN = 4'b1001;
  localparam logic [3:0] K_PCOIN = 4'b0011;
  localparam logic [3:0] K_DCOIN = 4'b0110;
  localparam logic [3:0] K_SPECL = 4'b1100;

  localparam logic [15:0] SPWORD_SYNC    = 16'h1111;
  localparam logic [15:0] SPWORD_START   = 16'h2222;
  localparam logic [15:0] SPWORD_END     = 16'h3333;
  localparam logic [15:0] SPWORD_SAVECLK = 16'h4444;

  localparam int RX_SINGLE = 7;
  localparam int RX_IDLE   = 6;
  localparam int RX_OFS_HI = 6;
  localparam int RX_OFS_LO = 1;
  localparam int RX_IDX_HI = 3;
  localparam int RX_IDX_LO = 2;

  typedef enum logic [2:0] {TX_IDLE, TX_SP3, TX_SP2, TX_SP1, TX_SP0} tx_state_t;
  typedef enum logic [1:0] {PREV_FIRST, PREV_SINGLE, PREV_IDLE, PREV_OTHER} rx_prev_t;

  function automatic logic [3:0] idle_code(input logic [1:0] k);
    case (k)
      2'd0:    return K_IDLE0;
      2'd1:    return K_IDLE1;
      2'd2:    return K_IDLE2;
      default: return K_IDLE3;
    endcase
  endfunction

  function automatic logic [3:0] coinc_code(input logic [1:0] t);
    case (t)
      2'd0:    return K_NCOIN;
      2'd1:    return K_PCOIN;
      default: return K_DCOIN;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mcu_coinc_fifo.sv
// Synchronous FIFO for queued coincidence responses; push while full is accepted only with a pop.
module mcu_coinc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mcu_rocstar_link.sv
// MCU-side endpoint of one ROCSTAR port: TX word scheduler (idle/coinc/special) and RX decoder.
module mcu_rocstar_link
  import mcu_link_pkg::*;
#(
  parameter int COINC_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  to_roc,
  input  logic [7:0]  from_roc,
  input  logic        do_testp,
  input  logic [3:0]  testpatt,
  input  logic        coinc_valid,
  input  logic [1:0]  coinc_type,
  input  logic        sp_req,
  input  logic [15:0] sp_data,
  output logic        sp_ack,
  output logic        sp_busy,
  output logic        single,
  output logic [5:0]  offset,
  output logic [15:0] roc_idlecnt,
  output logic        idlecnt_valid,
  output logic [15:0] badidle,
  output logic [15:0] badword,
  output logic [15:0] coinc_ovf,
  output logic [15:0] numsingl
);

  // ---------------- TX ----------------
  tx_state_t   state, state_nxt;
  logic [1:0]  idle_k, idle_k_nxt;
  logic [15:0] sp_word;
  logic [3:0]  word_nxt;
  logic        pop, ack_nxt, busy_nxt, sp_take;
  logic        fifo_full, fifo_empty;
  logic [1:0]  fifo_dout;
  logic        coinc_push;

  assign coinc_push = coinc_valid && (coinc_type != 2'd3);

  mcu_coinc_fifo #(.DEPTH(COINC_DEPTH), .WIDTH(2)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (coinc_push),
    .din   (coinc_type),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TX_IDLE;
      idle_k  <= 2'd0;
      sp_word <= '0;
      to_roc  <= K_IDLE3;
      sp_ack  <= 1'b0;
      sp_busy <= 1'b0;
    end else begin
      state   <= state_nxt;
      idle_k  <= idle_k_nxt;
      if (sp_take) sp_word <= sp_data;
      // Test pattern only masks the pins; the scheduler keeps advancing underneath.
      to_roc  <= do_testp ? testpatt : word_nxt;
      sp_ack  <= ack_nxt;
      sp_busy <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idle_k_nxt = 2'd0;
    word_nxt   = idle_code(idle_k);
    pop        = 1'b0;
    ack_nxt    = 1'b0;
    busy_nxt   = 1'b1;
    sp_take    = 1'b0;
    case (state)
      TX_IDLE: begin
        busy_nxt = 1'b0;
        if (!fifo_empty) begin
          pop      = 1'b1;
          word_nxt = coinc_code(fifo_dout);
        end else if (sp_req) begin
          sp_take   = 1'b1;
          word_nxt  = K_SPECL;
          ack_nxt   = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = TX_SP3;
        end else begin
          idle_k_nxt = idle_k + 2'd1;
        end
      end
      TX_SP3: begin word_nxt = sp_word[15:12]; state_nxt = TX_SP2;  end
      TX_SP2: begin word_nxt = sp_word[11:8];  state_nxt = TX_SP1;  end
      TX_SP1: begin word_nxt = sp_word[7:4];   state_nxt = TX_SP0;  end
      TX_SP0: begin word_nxt = sp_word[3:0];   state_nxt = TX_IDLE; end
      default: begin busy_nxt = 1'b0; state_nxt = TX_IDLE; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      coinc_ovf <= '0;
    else if (coinc_valid && (coinc_type == 2'd3 || (fifo_full && !pop)))
      coinc_ovf <= sat_inc(coinc_ovf);
  end

  // ---------------- RX ----------------
  rx_prev_t    prev;
  logic [1:0]  prev_j;
  logic [2:0]  chain_len;
  logic [11:0] chain_cnt;
  logic [1:0]  rx_j;
  logic [3:0]  rx_nib;
  logic        idle_ok;

  assign rx_j   = from_roc[RX_IDX_HI:RX_IDX_LO];
  assign rx_nib = {from_roc[5:4], from_roc[1:0]};

  always_comb begin
    idle_ok = 1'b0;
    if (rx_j == 2'd0)
      idle_ok = (prev == PREV_FIRST) || (prev == PREV_SINGLE) ||
                (prev == PREV_IDLE && prev_j == 2'd3);
    else
      idle_ok = (prev == PREV_IDLE) && (prev_j == rx_j - 2'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev          <= PREV_FIRST;
      prev_j        <= 2'd0;
      chain_len     <= '0;
      chain_cnt     <= '0;
      single        <= 1'b0;
      offset        <= '0;
      roc_idlecnt   <= '0;
      idlecnt_valid <= 1'b0;
      badidle       <= '0;
      badword       <= '0;
      numsingl      <= '0;
    end else begin
      single        <= 1'b0;
      idlecnt_valid <= 1'b0;
      if (from_roc[RX_SINGLE]) begin
        single    <= 1'b1;
        offset    <= from_roc[RX_OFS_HI:RX_OFS_LO];
        numsingl  <= numsingl + 16'd1;
        chain_len <= '0;
        prev      <= PREV_SINGLE;
      end else if (from_roc[RX_IDLE]) begin
        prev   <= PREV_IDLE;
        prev_j <= rx_j;
        if (!idle_ok) begin
          badidle   <= sat_inc(badidle);
          chain_len <= '0;
        end else if (rx_j == 2'd0) begin
          chain_cnt[3:0] <= rx_nib;
          chain_len      <= 3'd1;
        end else if (chain_len == {1'b0, rx_j}) begin
          if (rx_j == 2'd3) begin
            roc_idlecnt   <= {rx_nib, chain_cnt};
            idlecnt_valid <= 1'b1;
            chain_len     <= '0;
          end else begin
            chain_cnt[{rx_j, 2'b00} +: 4] <= rx_nib;
            chain_len <= chain_len + 3'd1;
          end
        end else begin
          // In-sequence word but the chain was broken earlier: wait for the next j=0.
          chain_len <= '0;
        end
      end else begin
        badword   <= sat_inc(badword);
        chain_len <= '0;
        prev      <= PREV_OTHER;
      end
    end
  end

endmodule

// File: tb/tb_mcu_rocstar_link.sv
// Directed bench for mcu_rocstar_link: TX sequencing, coincidence FIFO, RX idle recovery and error counters.
module tb_mcu_rocstar_link;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  to_roc;
  logic [7:0]  from_roc;
  logic        do_testp;
  logic [3:0]  testpatt;
  logic        coinc_valid;
  logic [1:0]  coinc_type;
  logic        sp_req;
  logic [15:0] sp_data;
  logic        sp_ack, sp_busy, single, idlecnt_valid;
  logic [5:0]  offset;
  logic [15:0] roc_idlecnt, badidle, badword, coinc_ovf, numsingl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mcu_rocstar_link #(.COINC_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .to_roc        (to_roc),
    .from_roc      (from_roc),
    .do_testp      (do_testp),
    .testpatt      (testpatt),
    .coinc_valid   (coinc_valid),
    .coinc_type    (coinc_type),
    .sp_req        (sp_req),
    .sp_data       (sp_data),
    .sp_ack        (sp_ack),
    .sp_busy       (sp_busy),
    .single        (single),
    .offset        (offset),
    .roc_idlecnt   (roc_idlecnt),
    .idlecnt_valid (idlecnt_valid),
    .badidle       (badidle),
    .badword       (badword),
    .coinc_ovf     (coinc_ovf),
    .numsingl      (numsingl)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  function automatic logic [7:0] mk_idle(input logic [1:0] j, input logic [3:0] n);
    return {2'b01, n[3:2], j, n[1:0]};
  endfunction

  initial begin
    logic [3:0]  idle_exp [4];
    logic [3:0]  sp_exp   [6];
    logic [3:0]  cc_exp   [7];
    logic [3:0]  ov_exp   [10];
    logic [1:0]  ov_type  [6];
    logic [15:0] loop_cnt;

    idle_exp = '{4'h7, 4'hB, 4'hD, 4'hE};
    loop_cnt = 16'hABCD;

    rst = 1'b1; from_roc = 8'h00; do_testp = 1'b0; testpatt = 4'h0;
    coinc_valid = 1'b0; coinc_type = 2'd0; sp_req = 1'b0; sp_data = 16'h0;
    step(); step();
    chk("rst_to_roc", to_roc, 4'hE);
    chk("rst_busy", sp_busy, 1'b0);
    chk("rst_ack", sp_ack, 1'b0);
    chk("rst_numsingl", numsingl, 16'h0);
    chk("rst_badword", badword, 16'h0);

    // Idle stream out, looped-back idle stream in carrying 0xABCD.
    rst = 1'b0;
    from_roc = mk_idle(2'd0, loop_cnt[3:0]);
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("idle_%0d", i), to_roc, idle_exp[i % 4]);
      from_roc = mk_idle(2'((i + 1) % 4), loop_cnt[((i + 1) % 4) * 4 +: 4]);
    end
    chk("loop_idlecnt", roc_idlecnt, 16'hABCD);
    chk("loop_valid", idlecnt_valid, 1'b1);
    chk("loop_badidle", badidle, 16'h0);
    from_roc = 8'h80;

    // Plain special word.
    sp_exp = '{4'hC, 4'h2, 4'h2, 4'h2, 4'h2, 4'h7};
    sp_req = 1'b1; sp_data = 16'h2222;
    for (int i = 0; i < 6; i++) begin
      step();
      sp_req = 1'b0;
      chk($sformatf("sp_word_%0d", i), to_roc, sp_exp[i]);
      chk($sformatf("sp_ack_%0d", i), sp_ack, (i == 0) ? 1'b1 : 1'b0);
      chk($sformatf("sp_busy_%0d", i), sp_busy, (i < 5) ? 1'b1 : 1'b0);
    end

    // PCOIN pushed on the SPECL cycle waits for the last nibble.
    cc_exp = '{4'hC, 4'h5, 4'hA, 4'h3, 4'hC, 4'h3, 4'h7};
    sp_req = 1'b1; sp_data = 16'h5A3C;
    for (int i = 0; i < 7; i++) begin
      step();
      sp_req = 1'b0;
      coinc_valid = (i == 0);
      coinc_type  = 2'd1;
      chk($sformatf("cc_word_%0d", i), to_roc, cc_exp[i]);
    end
    coinc_valid = 1'b0;

    // Six pushes during a special: one dropped on full, one illegal type.
    ov_type = '{2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd3};
    ov_exp  = '{4'hC, 4'h3, 4'h3, 4'h3, 4'h3, 4'h9, 4'h6, 4'h3, 4'h9, 4'h7};
    sp_req = 1'b1; sp_data = 16'h3333;
    coinc_valid = 1'b1; coinc_type = ov_type[0];
    for (int i = 0; i < 10; i++) begin
      step();
      sp_req = 1'b0;
      chk($sformatf("ov_word_%0d", i), to_roc, ov_exp[i]);
      if (i == 4) chk("ov_cnt_full", coinc_ovf, 16'd1);
      coinc_valid = (i < 5);
      coinc_type  = (i < 5) ? ov_type[i + 1] : 2'd0;
    end
    chk("ov_cnt_final", coinc_ovf, 16'd2);

    // Latency: coinc driven after edge n appears after edge n+2. Last word was IDLE0, so IDLE1 next.
    coinc_valid = 1'b1; coinc_type = 2'd2;
    step();
    coinc_valid = 1'b0;
    chk("lat_n1", to_roc, 4'hB);
    step();
    chk("lat_n2", to_roc, 4'h6);
    step();
    chk("lat_resume", to_roc, 4'h7);

    // Test pattern masks the output while the idle counter advances underneath.
    do_testp = 1'b1; testpatt = 4'h5;
    step();
    chk("testp", to_roc, 4'h5);
    do_testp = 1'b0;
    step();
    chk("testp_after", to_roc, 4'hD);

    // Held sp_req loses to a pending coincidence, then is accepted.
    coinc_valid = 1'b1; coinc_type = 2'd0;
    step();
    coinc_valid = 1'b0; sp_req = 1'b1; sp_data = 16'h4444;
    step();
    chk("prio_coinc", to_roc, 4'h9);
    chk("prio_noack", sp_ack, 1'b0);
    step();
    sp_req = 1'b0;
    chk("prio_specl", to_roc, 4'hC);
    chk("prio_ack", sp_ack, 1'b1);

    // RX: fresh reset, then idle counter recovery.
    rst = 1'b1;
    step();
    chk("rst2_ovf", coinc_ovf, 16'h0);
    chk("rst2_numsingl", numsingl, 16'h0);
    rst = 1'b0;
    from_roc = 8'h50; step();
    chk("rx_v0", idlecnt_valid, 1'b0);
    from_roc = 8'h47; step();
    from_roc = 8'h4A; step();
    chk("rx_v2", idlecnt_valid, 1'b0);
    from_roc = 8'h4D; step();
    chk("rx_idlecnt", roc_idlecnt, 16'h1234);
    chk("rx_valid", idlecnt_valid, 1'b1);
    from_roc = 8'hD4; step();
    chk("rx_single", single, 1'b1);
    chk("rx_offset", offset, 6'd42);
    chk("rx_numsingl", numsingl, 16'd1);
    chk("rx_valid_drop", idlecnt_valid, 1'b0);
    chk("rx_badidle0", badidle, 16'h0);

    // RX errors.
    from_roc = 8'h40; step();
    chk("err_first_ok", badidle, 16'h0);
    chk("err_single_drop", single, 1'b0);
    from_roc = 8'h40; step();
    chk("err_bad1", badidle, 16'd1);
    from_roc = 8'h48; step();
    from_roc = 8'h00; step();
    chk("err_badidle", badidle, 16'd2);
    chk("err_badword", badword, 16'd1);
    chk("err_novalid", idlecnt_valid, 1'b0);
    chk("err_idlecnt_hold", roc_idlecnt, 16'h1234);

    // Reset mid-stream clears everything on the next clk.
    from_roc = 8'h80; rst = 1'b1;
    step();
    chk("mid_badidle", badidle, 16'h0);
    chk("mid_badword", badword, 16'h0);
    chk("mid_numsingl", numsingl, 16'h0);
    chk("mid_ovf", coinc_ovf, 16'h0);
    chk("mid_idlecnt", roc_idlecnt, 16'h0);
    chk("mid_offset", offset, 6'h0);
    chk("mid_single", single, 1'b0);
    chk("mid_to_roc", to_roc, 4'hE);
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
